fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-aware write arbiter that shares one RaveNoC flit FIFO between N_REQ requesters.
- Grants one requester per cycle and forwards its flit to the FIFO write port.
- Holds the grant (wormhole lock) from a packet's first flit until its last flit, so packets never interleave inside the FIFO.
- Sits directly in front of the fifo instance; backpressure comes from the FIFO full flag.

Parameters:
- N_REQ, 4, number of requesters (must be >= 2).
- WIDTH, 34, flit width in bits; matches the FIFO WIDTH.

Ports:
- clk  input  1  clock.
- arst  input  1  reset; asynchronous, active-low.
- valid_i  input  N_REQ  per-requester flit valid.
- last_i  input  N_REQ  per-requester flag: the current flit is the packet's last flit.
- data_i  input  N_REQ*WIDTH  flits; requester k occupies bits [k*WIDTH +: WIDTH].
- ready_o  output  N_REQ  per-requester accept; a flit transfers when valid_i[k] and ready_o[k] are both high.
- fifo_write_o  output  1  FIFO write strobe.
- fifo_data_o  output  WIDTH  flit of the granted requester.
- fifo_full_i  input  1  FIFO full flag.
- grant_o  output  N_REQ  one-hot current grant; all zero when nothing is granted.
- locked_o  output  1  high while a multi-flit packet owns the FIFO.

Behaviour:
- Registers:
  - state: IDLE or LOCKED.
  - ptr: $clog2(N_REQ) bits, highest-priority index.
  - owner: $clog2(N_REQ) bits.
- Reset (arst low, asynchronous):
  - state=IDLE, ptr=0, owner=0.
  - While arst is low, all outputs are forced to 0.
- IDLE arbitration (combinational):
  - Winner g is the first k with valid_i[k]=1, searching ptr, ptr+1, ..., N_REQ-1, then 0, ..., ptr-1.
  - No valid requester: grant_o=0, fifo_write_o=0.
- LOCKED: g=owner regardless of the other valids; grant_o is one-hot on owner even when valid_i[owner]=0.
- Outputs (combinational, zero-latency pass-through):
  - ready_o[g] = ~fifo_full_i; ready_o of every other requester = 0.
  - fifo_write_o = valid_i[g] & ~fifo_full_i.
  - fifo_data_o = data_i slice g; value is don't-care when fifo_write_o=0.
  - locked_o = (state==LOCKED).
- Transitions, evaluated on a transfer (fifo_write_o=1):
  - IDLE, last_i[g]=1: stay IDLE; ptr <= (g+1) mod N_REQ.
  - IDLE, last_i[g]=0: go LOCKED; owner <= g; ptr unchanged.
  - LOCKED, last_i[owner]=1: go IDLE; ptr <= (owner+1) mod N_REQ.
  - LOCKED, last_i[owner]=0: stay LOCKED.
- Stalls:
  - No transfer means no state, ptr or owner change.
  - A stalled IDLE winner is not reserved: the next cycle re-arbitrates from the unchanged ptr.
  - A gap (valid_i[owner]=0) in LOCKED keeps the lock.
- Fairness:
  - Each completed packet moves ptr past its sender.
  - Any continuously-valid requester is granted within N_REQ-1 packets.
- Pointer wrap: (N_REQ-1)+1 wraps to 0; for non-power-of-2 N_REQ, the explicit modulo applies.
- Single-flit packet (last_i=1 on the first flit) never enters LOCKED.
- Throughput: one flit per cycle with no bubbles, including between back-to-back packets from different requesters.
- Reset mid-packet drops the lock immediately. Removing partial packets already in the FIFO is outside this block.

Test Plan:
- Reset then idle: arst=0 with random inputs -> all outputs 0. Release with valid_i=0 -> grant_o=0, fifo_write_o=0, locked_o=0.
- Round robin: all 4 requesters valid with single-flit packets, full=0 -> grants in order 0,1,2,3,0 on consecutive cycles; fifo_data_o matches each slice; 5 writes in 5 cycles.
- Wormhole lock: req1 sends 3 flits (last on flit 3) while req0 and req2 stay valid -> grant_o=4'b0010 for 3 cycles, locked_o=1 during cycles 1-2, then req2 is granted (ptr=2).
- Backpressure: fifo_full_i=1 mid-packet for 4 cycles -> fifo_write_o=0, ready_o=0, locked_o stays 1, owner unchanged. Deassert full -> remaining flits resume the next cycle with no loss or duplication.
- Gap in lock: owner drops valid for 2 cycles while req3 is valid -> req3 never receives ready_o, no writes occur, and the lock holds until the owner's last flit.
- Async reset mid-packet: arst low during LOCKED, between clock edges -> locked_o=0 immediately. After release, requester 0 wins first (ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signal bundle for fifo_wr_arbiter.
// master drives requests and the full flag; slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 34
);
    logic [N_REQ-1:0]       valid_i;
    logic [N_REQ-1:0]       last_i;
    logic [N_REQ*WIDTH-1:0] data_i;
    logic [N_REQ-1:0]       ready_o;
    logic                   fifo_write_o;
    logic [WIDTH-1:0]       fifo_data_o;
    logic                   fifo_full_i;
    logic [N_REQ-1:0]       grant_o;
    logic                   locked_o;

    modport master (
        output valid_i, last_i, data_i, fifo_full_i,
        input  ready_o, fifo_write_o, fifo_data_o, grant_o, locked_o
    );

    modport slave (
        input  valid_i, last_i, data_i, fifo_full_i,
        output ready_o, fifo_write_o, fifo_data_o, grant_o, locked_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware write arbiter sharing one flit FIFO between N_REQ requesters.
// A packet's first non-last flit locks the grant to its sender until the last flit transfers.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic               clk,
    input  logic               arst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] owner, owner_nxt;

    logic [PW-1:0] win_c;
    logic          win_vld_c;
    logic          xfer_c;
    logic          found;
    int unsigned   idx;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] cur);
        next_idx = PW'((32'(cur) + 32'd1) % N_REQ);
    endfunction

    // State register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // Winner selection: owner while locked, else first valid at or after ptr
    always_comb begin
        win_c     = owner;
        win_vld_c = (state == LOCKED);
        found     = 1'b0;
        idx       = 0;
        if (state == IDLE) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                idx = (32'(ptr) + i) % N_REQ;
                if (!found && bus.valid_i[idx]) begin
                    found = 1'b1;
                    win_c = PW'(idx);
                end
            end
            win_vld_c = found;
        end
        xfer_c = win_vld_c & bus.valid_i[win_c] & ~bus.fifo_full_i;
    end

    // Next-state logic; only a transfer moves state, ptr or owner
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (xfer_c) begin
            case (state)
                IDLE: begin
                    if (bus.last_i[win_c]) begin
                        ptr_nxt = next_idx(win_c);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = win_c;
                    end
                end
                LOCKED: begin
                    if (bus.last_i[owner]) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_idx(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Zero-latency outputs, forced low while reset is asserted
    always_comb begin
        bus.grant_o      = '0;
        bus.ready_o      = '0;
        bus.fifo_write_o = 1'b0;
        bus.fifo_data_o  = '0;
        bus.locked_o     = 1'b0;
        if (arst) begin
            bus.locked_o = (state == LOCKED);
            if (win_vld_c) begin
                bus.grant_o[win_c] = 1'b1;
                bus.ready_o[win_c] = ~bus.fifo_full_i;
                bus.fifo_write_o   = xfer_c;
                bus.fifo_data_o    = bus.data_i[32'(win_c)*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic
// compared each cycle against a packet-level reference model.
module tb_fifo_wr_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned W = 34;

    logic clk;
    logic arst;

    fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state
    bit           m_locked;
    int           m_owner;
    int           m_ptr;

    // Expected outputs for the current cycle
    int           e_g;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    logic         e_write;
    logic [W-1:0] e_data;
    logic         e_locked;

    logic [2*N+1:0] obs_ctrl;
    logic [2*N+1:0] exp_ctrl;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
    endfunction

    // Expected outputs straight from the arbitration rules
    function automatic void model_eval();
        logic [W-1:0] slice;
        e_g      = -1;
        e_grant  = '0;
        e_ready  = '0;
        e_write  = 1'b0;
        e_data   = '0;
        e_locked = 1'b0;
        if (arst) begin
            e_locked = m_locked;
            if (m_locked) e_g = m_owner;
            else begin
                for (int k = 0; k < int'(N); k++) begin
                    if (e_g < 0 && bus.valid_i[(m_ptr + k) % int'(N)]) e_g = (m_ptr + k) % int'(N);
                end
            end
            if (e_g >= 0) begin
                e_grant[e_g] = 1'b1;
                e_ready[e_g] = ~bus.fifo_full_i;
                e_write      = bus.valid_i[e_g] & ~bus.fifo_full_i;
                slice        = bus.data_i[e_g*int'(W) +: W];
                e_data       = slice;
            end
        end
        exp_ctrl = {e_grant, e_ready, e_write, e_locked};
        obs_ctrl = {bus.grant_o, bus.ready_o, bus.fifo_write_o, bus.locked_o};
    endfunction

    function automatic void model_commit();
        if (e_write) begin
            if (!m_locked) begin
                if (bus.last_i[e_g]) m_ptr = (e_g + 1) % int'(N);
                else begin
                    m_locked = 1'b1;
                    m_owner  = e_g;
                end
            end else if (bus.last_i[m_owner]) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % int'(N);
            end
        end
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        bus.valid_i     = v;
        bus.last_i      = l;
        bus.fifo_full_i = f;
        for (int k = 0; k < int'(N); k++) bus.data_i[k*int'(W) +: W] = W'({$urandom(), $urandom()});
    endtask

    task automatic test_reset();
        arst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(N'($urandom()), N'($urandom()), 1'($urandom()));
            #2;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl || bus.fifo_data_o !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs ctrl got %h expected %h data got %h", obs_ctrl, exp_ctrl, bus.fifo_data_o);
            end
        end
        @(posedge clk); #1;
        arst = 1'b1;
        drive('0, '0, 1'b0);
        #3;
        model_eval();
        n_checks++;
        if (obs_ctrl !== exp_ctrl || bus.grant_o !== '0 || bus.locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle ctrl got %h expected %h", obs_ctrl, exp_ctrl);
        end
        model_commit();
    endtask

    task automatic test_round_robin();
        int writes = 0;
        logic [N-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive('1, '1, 1'b0);
            #3;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl || bus.grant_o !== order[i]) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d ctrl got %h expected %h", i, obs_ctrl, exp_ctrl);
            end
            n_checks++;
            if (bus.fifo_data_o !== e_data) begin
                n_fail++;
                $display("FAIL rr_data cycle %0d got %h expected %h", i, bus.fifo_data_o, e_data);
            end
            if (bus.fifo_write_o === 1'b1) writes++;
            model_commit();
        end
        n_checks++;
        if (writes !== 5) begin
            n_fail++;
            $display("FAIL rr_write_count got %0d expected 5", writes);
        end
    endtask

    task automatic test_wormhole();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) drive(4'b0111, (i == 2) ? 4'b0111 : 4'b0101, 1'b0);
            else       drive(4'b0101, 4'b0101, 1'b0);
            #3;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl || bus.grant_o !== ((i < 3) ? 4'b0010 : 4'b0100)) begin
                n_fail++;
                $display("FAIL wormhole cycle %0d ctrl got %h expected %h", i, obs_ctrl, exp_ctrl);
            end
            n_checks++;
            if (e_write && bus.fifo_data_o !== e_data) begin
                n_fail++;
                $display("FAIL wormhole_data cycle %0d got %h expected %h", i, bus.fifo_data_o, e_data);
            end
            model_commit();
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        logic full;
        // requester 3 sends 5 flits; FIFO reports full for 4 cycles after flit 2
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            full = (i >= 2 && i < 6);
            drive(4'b1011, (sent == 4) ? 4'b1011 : 4'b0011, full);
            #3;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl || (full && (bus.locked_o !== 1'b1 || bus.ready_o !== '0))) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d ctrl got %h expected %h", i, obs_ctrl, exp_ctrl);
            end
            n_checks++;
            if (e_write && bus.fifo_data_o !== e_data) begin
                n_fail++;
                $display("FAIL backpressure_data cycle %0d got %h expected %h", i, bus.fifo_data_o, e_data);
            end
            if (bus.fifo_write_o === 1'b1 && bus.grant_o === 4'b1000) sent++;
            model_commit();
        end
        n_checks++;
        if (sent !== 5 || m_locked) begin
            n_fail++;
            $display("FAIL backpressure_flits got %0d expected 5", sent);
        end
    endtask

    task automatic test_gap();
        logic [N-1:0] v [5];
        logic [N-1:0] l [5];
        v[0] = 4'b0001; v[1] = 4'b1000; v[2] = 4'b1000; v[3] = 4'b1001; v[4] = 4'b1001;
        l[0] = 4'b1000; l[1] = 4'b1000; l[2] = 4'b1000; l[3] = 4'b1000; l[4] = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(v[i], l[i], 1'b0);
            #3;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl || bus.ready_o[3] !== 1'b0 || bus.grant_o !== 4'b0001) begin
                n_fail++;
                $display("FAIL gap cycle %0d ctrl got %h expected %h", i, obs_ctrl, exp_ctrl);
            end
            model_commit();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(4'b0100, 4'b0000, 1'b0);
            #3;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d ctrl got %h expected %h", i, obs_ctrl, exp_ctrl);
            end
            model_commit();
        end
        #2;
        arst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.locked_o !== 1'b0 || bus.grant_o !== '0 || bus.fifo_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset locked got %b grant got %b expected 0", bus.locked_o, bus.grant_o);
        end
        @(posedge clk); #1;
        arst = 1'b1;
        drive('1, '1, 1'b0);
        #3;
        model_eval();
        n_checks++;
        if (obs_ctrl !== exp_ctrl || bus.grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_grant ctrl got %h expected %h", obs_ctrl, exp_ctrl);
        end
        model_commit();
    endtask

    task automatic test_random();
        logic [N-1:0] v, l;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < int'(N); k++) begin
                v[k] = ($urandom_range(0, 99) < 60);
                l[k] = ($urandom_range(0, 99) < 35);
            end
            drive(v, l, ($urandom_range(0, 99) < 20));
            #3;
            model_eval();
            n_checks++;
            if (obs_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL random cycle %0d ctrl got %h expected %h", i, obs_ctrl, exp_ctrl);
            end
            n_checks++;
            if (e_write && bus.fifo_data_o !== e_data) begin
                n_fail++;
                $display("FAIL random_data cycle %0d got %h expected %h", i, bus.fifo_data_o, e_data);
            end
            model_commit();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_backpressure();
        test_gap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
